// File: rtl/game_pkg.sv
// Shared game geometry, car defaults and the car controller state encoding.
package game_pkg;

    localparam int unsigned ROAD_X_MIN = 128;
    localparam int unsigned ROAD_X_MAX = 255;
    localparam int unsigned CAR_W      = 16;
    localparam int unsigned CAR_H      = 32;
    localparam int unsigned SCREEN_H   = 480;

    localparam int unsigned CAR_X_START      = 184;
    localparam int unsigned CAR_Y_START      = 400;
    localparam int unsigned CAR_STEP         = 2;
    localparam int unsigned CAR_CRASH_FRAMES = 120;
    localparam int unsigned CAR_BLINK_SHIFT  = 3;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StCrash   = 2'd1,
        StRespawn = 2'd2
    } car_state_e;

endpackage

// File: rtl/car_position_controller_if.sv
// Button/crash inputs and car position outputs between the game logic and the renderer.
interface car_position_controller_if;

    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic       crash;
    logic [7:0] car_position_x;
    logic [9:0] car_position_y;
    logic       update;
    logic       car_visible;
    logic       crashed;

    modport master (
        output frame_tick, btn_left, btn_right, btn_up, btn_down, crash,
        input  car_position_x, car_position_y, update, car_visible, crashed
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, btn_up, btn_down, crash,
        output car_position_x, car_position_y, update, car_visible, crashed
    );

endinterface

// File: rtl/car_axis_step.sv
// Combinational saturating step along one axis; both or neither direction means no move.
module car_axis_step #(
    parameter int unsigned Width = 10
) (
    input  logic [Width-1:0] cur_i,
    input  logic             dec_i,
    input  logic             inc_i,
    input  logic [Width-1:0] step_i,
    input  logic [Width-1:0] min_i,
    input  logic [Width-1:0] max_i,
    output logic [Width-1:0] next_o,
    output logic             changed_o
);

    // 11-bit signed so a step below zero clamps instead of wrapping
    logic signed [10:0] sum;

    always_comb begin
        sum = $signed(11'(cur_i));
        if (inc_i && !dec_i) begin
            sum = sum + $signed(11'(step_i));
        end else if (dec_i && !inc_i) begin
            sum = sum - $signed(11'(step_i));
        end

        if (sum < $signed(11'(min_i))) begin
            next_o = min_i;
        end else if (sum > $signed(11'(max_i))) begin
            next_o = max_i;
        end else begin
            next_o = sum[Width-1:0];
        end
        changed_o = (next_o != cur_i);
    end

endmodule

// File: rtl/car_position_controller.sv
// Owns the car state: per-frame movement, crash freeze with blinking, respawn.
module car_position_controller
    import game_pkg::*;
#(
    parameter int unsigned X_MIN        = ROAD_X_MIN,
    parameter int unsigned X_MAX        = ROAD_X_MAX - CAR_W,
    parameter int unsigned Y_MIN        = 0,
    parameter int unsigned Y_MAX        = SCREEN_H - CAR_H - 1,
    parameter int unsigned X_START      = CAR_X_START,
    parameter int unsigned Y_START      = CAR_Y_START,
    parameter int unsigned STEP_X       = CAR_STEP,
    parameter int unsigned STEP_Y       = CAR_STEP,
    parameter int unsigned CRASH_FRAMES = CAR_CRASH_FRAMES,
    parameter int unsigned BLINK_SHIFT  = CAR_BLINK_SHIFT
) (
    input logic                      clk,
    input logic                      reset_n,
    car_position_controller_if.slave bus
);

    localparam logic [7:0] XStart      = 8'(X_START);
    localparam logic [9:0] YStart      = 10'(Y_START);
    localparam logic [7:0] CrashFrames = 8'(CRASH_FRAMES);

    car_state_e state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] cnt_q, cnt_d;
    logic       upd_q, upd_d;
    logic       vis_q, vis_d;
    logic       crashed_q, crashed_d;

    logic [7:0] x_step;
    logic [9:0] y_step;
    logic       x_chg, y_chg;

    car_axis_step #(.Width(8)) u_step_x (
        .cur_i    (x_q),
        .dec_i    (bus.btn_left),
        .inc_i    (bus.btn_right),
        .step_i   (8'(STEP_X)),
        .min_i    (8'(X_MIN)),
        .max_i    (8'(X_MAX)),
        .next_o   (x_step),
        .changed_o(x_chg)
    );

    car_axis_step #(.Width(10)) u_step_y (
        .cur_i    (y_q),
        .dec_i    (bus.btn_up),
        .inc_i    (bus.btn_down),
        .step_i   (10'(STEP_Y)),
        .min_i    (10'(Y_MIN)),
        .max_i    (10'(Y_MAX)),
        .next_o   (y_step),
        .changed_o(y_chg)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        upd_d     = 1'b0;
        vis_d     = vis_q;
        crashed_d = crashed_q;
        unique case (state_q)
            StRun: begin
                // crash wins over a coincident frame tick
                if (bus.crash) begin
                    state_d   = StCrash;
                    crashed_d = 1'b1;
                    cnt_d     = CrashFrames;
                end else if (bus.frame_tick) begin
                    x_d   = x_step;
                    y_d   = y_step;
                    upd_d = (x_chg || y_chg) && !upd_q;
                end
            end
            StCrash: begin
                if (bus.frame_tick) begin
                    cnt_d = cnt_q - 8'd1;
                    vis_d = ~cnt_d[BLINK_SHIFT];
                    if (cnt_q == 8'd1) begin
                        state_d = StRespawn;
                    end
                end
            end
            StRespawn: begin
                x_d       = XStart;
                y_d       = YStart;
                cnt_d     = 8'd0;
                vis_d     = 1'b1;
                crashed_d = 1'b0;
                upd_d     = ((x_q != XStart) || (y_q != YStart)) && !upd_q;
                state_d   = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StRun;
            x_q       <= XStart;
            y_q       <= YStart;
            cnt_q     <= 8'd0;
            upd_q     <= 1'b0;
            vis_q     <= 1'b1;
            crashed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            upd_q     <= upd_d;
            vis_q     <= vis_d;
            crashed_q <= crashed_d;
        end
    end

    assign bus.car_position_x = x_q;
    assign bus.car_position_y = y_q;
    assign bus.update         = upd_q;
    assign bus.car_visible    = vis_q;
    assign bus.crashed        = crashed_q;

endmodule

// File: tb/tb_car_position_controller.sv
// Bench for car_position_controller: default DUT plus a STEP_X=4 copy fed the same inputs.
module tb_car_position_controller;
    import game_pkg::*;

    localparam int MRun     = 0;
    localparam int MCrash   = 1;
    localparam int MRespawn = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    car_position_controller_if bus0 ();
    car_position_controller_if bus1 ();

    assign bus1.frame_tick = bus0.frame_tick;
    assign bus1.btn_left   = bus0.btn_left;
    assign bus1.btn_right  = bus0.btn_right;
    assign bus1.btn_up     = bus0.btn_up;
    assign bus1.btn_down   = bus0.btn_down;
    assign bus1.crash      = bus0.crash;

    car_position_controller u_dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus0.slave)
    );

    car_position_controller #(.STEP_X(4)) u_dut4 (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus1.slave)
    );

    typedef struct {
        int x;
        int y;
        int mode;
        int cnt;
        bit vis;
        bit upd;
        bit crashed;
    } car_m_t;

    typedef struct {
        bit l;
        bit r;
        bit u;
        bit d;
        int ex;
        int ey;
        bit eu;
    } vec_t;

    car_m_t m[2];
    int     step_x[2] = '{2, 4};
    vec_t   vq[$];
    int     checks = 0;
    int     errors = 0;

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) m[i] = '{184, 400, MRun, 0, 1'b1, 1'b0, 1'b0};
    endtask

    // Frame-level behaviour of the car, one call per clock edge
    task automatic model_step(input bit t, input bit l, input bit r, input bit u, input bit d,
                              input bit c);
        int nx, ny;
        for (int i = 0; i < 2; i++) begin
            case (m[i].mode)
                MRun: begin
                    if (c) begin
                        m[i].mode = MCrash;
                        m[i].crashed = 1'b1;
                        m[i].cnt = 120;
                        m[i].upd = 1'b0;
                    end else if (t) begin
                        nx = clampi(m[i].x + step_x[i] * (int'(r) - int'(l)), 128, 239);
                        ny = clampi(m[i].y + 2 * (int'(d) - int'(u)), 0, 447);
                        m[i].upd = (nx != m[i].x) || (ny != m[i].y);
                        m[i].x = nx;
                        m[i].y = ny;
                    end else begin
                        m[i].upd = 1'b0;
                    end
                end
                MCrash: begin
                    m[i].upd = 1'b0;
                    if (t) begin
                        if (m[i].cnt == 1) m[i].mode = MRespawn;
                        m[i].cnt = m[i].cnt - 1;
                        m[i].vis = ((m[i].cnt / 8) % 2) == 0;
                    end
                end
                default: begin
                    m[i].upd = (m[i].x != 184) || (m[i].y != 400);
                    m[i].x = 184;
                    m[i].y = 400;
                    m[i].vis = 1'b1;
                    m[i].crashed = 1'b0;
                    m[i].cnt = 0;
                    m[i].mode = MRun;
                end
            endcase
        end
    endtask

    task automatic check_all();
        check("x0", int'(bus0.car_position_x), m[0].x);
        check("y0", int'(bus0.car_position_y), m[0].y);
        check("update0", int'(bus0.update), int'(m[0].upd));
        check("visible0", int'(bus0.car_visible), int'(m[0].vis));
        check("crashed0", int'(bus0.crashed), int'(m[0].crashed));
        check("x4", int'(bus1.car_position_x), m[1].x);
        check("y4", int'(bus1.car_position_y), m[1].y);
        check("update4", int'(bus1.update), int'(m[1].upd));
        check("visible4", int'(bus1.car_visible), int'(m[1].vis));
        check("crashed4", int'(bus1.crashed), int'(m[1].crashed));
    endtask

    // Called at a falling edge; drives inputs, clocks once, checks at the next falling edge
    task automatic cycle(input bit t, input bit l, input bit r, input bit u, input bit d,
                         input bit c);
        bus0.frame_tick = t;
        bus0.btn_left   = l;
        bus0.btn_right  = r;
        bus0.btn_up     = u;
        bus0.btn_down   = d;
        bus0.crash      = c;
        @(posedge clk);
        model_step(t, l, r, u, d, c);
        @(negedge clk);
        check_all();
    endtask

    task automatic frame(input bit l, input bit r, input bit u, input bit d);
        cycle(1'b1, l, r, u, d, 1'b0);
        cycle(1'b0, l, r, u, d, 1'b0);
        cycle(1'b0, l, r, u, d, 1'b0);
    endtask

    function automatic void add(input bit l, input bit r, input bit u, input bit d,
                                input int ex, input int ey, input bit eu);
        vq.push_back('{l, r, u, d, ex, ey, eu});
    endfunction

    bit t_rand;
    int gap;

    initial begin
        for (int k = 1; k <= 5; k++)   add(0, 0, 0, 0, 184, 400, 0);
        for (int k = 1; k <= 30; k++)  add(0, 1, 0, 0, clampi(184 + 2 * k, 0, 239), 400, k <= 28);
        for (int k = 1; k <= 60; k++)  add(1, 0, 0, 0, clampi(239 - 2 * k, 128, 999), 400, k <= 56);
        for (int k = 1; k <= 3; k++)   add(1, 1, 0, 0, 128, 400, 0);
        for (int k = 1; k <= 202; k++) add(0, 0, 1, 0, 128, clampi(400 - 2 * k, 0, 999), k <= 200);
        for (int k = 1; k <= 226; k++) add(0, 0, 0, 1, 128, clampi(2 * k, 0, 447), k <= 224);
        for (int k = 1; k <= 2; k++)   add(0, 0, 1, 1, 128, 447, 0);

        reset_n = 1'b0;
        bus0.frame_tick = 1'b0;
        bus0.btn_left   = 1'b0;
        bus0.btn_right  = 1'b0;
        bus0.btn_up     = 1'b0;
        bus0.btn_down   = 1'b0;
        bus0.crash      = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_x", int'(bus0.car_position_x), 184);
        check("reset_y", int'(bus0.car_position_y), 400);
        check("reset_update", int'(bus0.update), 0);
        check("reset_visible", int'(bus0.car_visible), 1);
        check("reset_crashed", int'(bus0.crashed), 0);
        reset_n = 1'b1;

        foreach (vq[i]) begin
            cycle(1'b1, vq[i].l, vq[i].r, vq[i].u, vq[i].d, 1'b0);
            check("vec_x", int'(bus0.car_position_x), vq[i].ex);
            check("vec_y", int'(bus0.car_position_y), vq[i].ey);
            check("vec_update", int'(bus0.update), int'(vq[i].eu));
            cycle(1'b0, vq[i].l, vq[i].r, vq[i].u, vq[i].d, 1'b0);
            check("vec_update_pulse", int'(bus0.update), 0);
            cycle(1'b0, vq[i].l, vq[i].r, vq[i].u, vq[i].d, 1'b0);
        end

        // Crash together with a tick and btn_right: no move, crashed next cycle
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("crash_crashed", int'(bus0.crashed), 1);
        check("crash_x_frozen", int'(bus0.car_position_x), 128);
        check("crash_no_update", int'(bus0.update), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 120; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            check("blink", int'(bus0.car_visible), int'((((k - 1) / 8) % 2) == 0));
            check("crash_held", int'(bus0.crashed), 1);
            check("crash_frozen_x", int'(bus0.car_position_x), 128);
            if (k < 120) begin
                cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("respawn_x", int'(bus0.car_position_x), 184);
        check("respawn_y", int'(bus0.car_position_y), 400);
        check("respawn_update", int'(bus0.update), 1);
        check("respawn_crashed", int'(bus0.crashed), 0);
        check("respawn_visible", int'(bus0.car_visible), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("respawn_update_drop", int'(bus0.update), 0);

        // Reset in the middle of a crash, with frame_cnt at 50
        for (int k = 0; k < 5; k++) frame(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 70; k++) frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("precrash_x", int'(bus0.car_position_x), 174);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("areset_x", int'(bus0.car_position_x), 184);
        check("areset_y", int'(bus0.car_position_y), 400);
        check("areset_update", int'(bus0.update), 0);
        check("areset_visible", int'(bus0.car_visible), 1);
        check("areset_crashed", int'(bus0.crashed), 0);
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("post_reset_y", int'(bus0.car_position_y), 402);
        check("post_reset_update", int'(bus0.update), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random buttons, crashes and ticks at least three cycles apart
        gap = 2;
        for (int i = 0; i < 4000; i++) begin
            t_rand = (gap >= 2) && ($urandom_range(0, 2) == 0);
            gap = t_rand ? 0 : gap + 1;
            cycle(t_rand, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 59) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
